normalise_pipe: RTL and testbench
=================================

# normalise_pipe

Pipelined, parametrised posit normaliser with valid/ready flow control. Takes the raw mantissa sum and interim regime/exponent from the posit adder datapath. Renormalises with any exponent size `ES`, clamps the regime to the legal posit range and flags zero and saturation. Sits between the adder core and the posit encode/round stage, and sustains one result per cycle under backpressure.

## Interface
- `WIDTH`, 8: posit word width `n`.
- `ES`, 1: exponent field size, 0..3.
- `W_MAN`, `WIDTH`: mantissa_sum width.
- `W_REG`, `$clog2(WIDTH)+1`: signed regime width.
- `W_EXP`, `$clog2(WIDTH)+1`: signed interim exponent width.
- `TAG_W`, 4: opaque sideband tag carried alongside the data.

Ports:
- `clk`  in  1  clock. One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  stage 1 can accept a beat.
- `mantissa_sum`  in  W_MAN  unsigned raw sum.
- `interim_regime`  in  W_REG  signed regime `k`.
- `interim_exponent`  in  W_EXP  signed exponent offset `e`.
- `in_tag`  in  TAG_W  sideband tag.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts.
- `mantissa`  out  W_MAN  fraction with the hidden 1 removed, MSB-aligned.
- `regime`  out  W_REG  signed normalised regime.
- `exponent`  out  ES (min 1)  unsigned normalised exponent, 0..2^ES-1.
- `is_zero`, `sat_hi`, `sat_lo`  out  1 each  result flags.
- `out_tag`  out  TAG_W  tag of the beat.

## Operation
- Stage 1 (registered on accept):
  - `nz` = leading-zero count of `mantissa_sum`.
  - `mant1` = `mantissa_sum << (nz+1)`, truncated to W_MAN.
  - `scale` = `(interim_regime <<< ES) + interim_exponent + 1 - nz`.
  - `zero` = (`mantissa_sum == 0`).
  - Internal scale width is W_REG+ES+2 signed, so no intermediate overflows.
- Stage 2 (registered on accept):
  - `r` = `scale >>> ES` (arithmetic, i.e. floor).
  - `x` = `scale[ES-1:0]`. If ES=0, `x`=0.
  - Legal regime range is `RMIN = -(WIDTH-1)` to `RMAX = WIDTH-2`.
  - If `zero`: mantissa=0, exponent=0, regime={1'b1, zeros} (most-negative code), is_zero=1. Zero takes priority over saturation.
  - Else if `r > RMAX`: regime=RMAX, exponent=0, mantissa=0, sat_hi=1.
  - Else if `r < RMIN`: regime=RMIN, exponent=0, mantissa=0, sat_lo=1.
  - Else: regime=`r`, exponent=`x`, mantissa=`mant1`, all flags 0.
  - At most one flag is high per beat.
- Tag travels with its beat unchanged.

## Timing
- Latency is 2 cycles from input acceptance (`in_valid && in_ready` at edge T) to `out_valid` high after edge T+1.
- Throughput is 1 beat/cycle while `out_ready` = 1.
- Per-stage flow control:
  - `s2_rdy = !s2_v || out_ready`
  - `s1_rdy = !s1_v || s2_rdy`
  - `in_ready = s1_rdy`
  - The ready chain is combinational; `in_ready` never depends on `in_valid`.
- A stage loads when its upstream is valid and the stage is ready. A stage that is not ready holds its data and valid bit unchanged.
- Output data and flags stay stable while `out_valid && !out_ready` (AXI-style hold).
- Simultaneous load and drain in the same cycle: the stage takes the new beat, with no bubble.
- Reset:
  - Clears `s1_v` and `s2_v`, so `out_valid`=0 and `in_ready`=1 in the first cycle after reset.
  - Data registers, `regime`, `exponent`, `mantissa` and `out_tag` reset to 0. Flags reset to 0.
  - Reset mid-stream drops every in-flight beat. No partial beat is emitted afterwards.
- `in_valid` is ignored during reset.
- `in_valid` low with `in_ready` high inserts a bubble.

## Test plan
All cases use WIDTH=8, ES=1, W_MAN=8 unless stated.
- **Basic normalise:** `mantissa_sum=8'b0011_0000`, k=0, e=0 -> after 2 cycles: mantissa=8'b1000_0000, regime=-1, exponent=1, flags 0.
- **Carry / regime up:** `8'b1000_0000`, k=2, e=1 -> mantissa=0, scale=6, regime=3, exponent=0.
- **Zero and saturation:**
  - `mantissa_sum=0`, k=5 -> is_zero=1, regime=4'b1000, exponent=0, mantissa=0.
  - `8'b1000_0000`, k=6, e=1 -> sat_hi=1, regime=6.
  - `8'b0000_0001`, k=-7, e=0 -> scale=-20, sat_lo=1, regime=-7.
- **Backpressure:**
  - Stream tags 0..9 with `out_ready` toggled on a pseudo-random pattern.
  - Output must be the tags in order, each exactly once.
  - Output must stay stable while stalled.
  - With `out_ready` held at 1, `in_ready` must never drop.
  - With `out_ready`=0, exactly 2 beats are accepted before `in_ready`=0.
- **Reset mid-stream:** assert `rst` for 1 cycle with both stages full -> next cycle `out_valid`=0, `in_ready`=1. Beats accepted afterwards emerge with correct latency and no stale output.
- **ES sweep:** ES=0, 2 and 3, random inputs against a scoreboard model of the scale/floor/clamp equations. Includes `interim_exponent` extremes (-8 and 7).

Source files
------------

// File: rtl/normalise_pipe.sv
// Two-stage posit normaliser: leading-zero renormalise and scale in stage 1,
// regime/exponent split with range clamping and zero/saturation flags in stage 2.
module normalise_pipe #(
  parameter int WIDTH = 8,
  parameter int ES    = 1,
  parameter int W_MAN = WIDTH,
  parameter int W_REG = $clog2(WIDTH) + 1,
  parameter int W_EXP = $clog2(WIDTH) + 1,
  parameter int TAG_W = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [W_MAN-1:0]                  mantissa_sum,
  input  logic signed [W_REG-1:0]           interim_regime,
  input  logic signed [W_EXP-1:0]           interim_exponent,
  input  logic [TAG_W-1:0]                  in_tag,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [W_MAN-1:0]                  mantissa,
  output logic signed [W_REG-1:0]           regime,
  output logic [((ES > 0) ? ES : 1)-1:0]    exponent,
  output logic                              is_zero,
  output logic                              sat_hi,
  output logic                              sat_lo,
  output logic [TAG_W-1:0]                  out_tag
);

  localparam int EW     = (ES > 0) ? ES : 1;
  localparam int SW     = W_REG + ES + 2;
  localparam int NZ_W   = $clog2(W_MAN + 1);
  localparam int RMAX_I = WIDTH - 2;
  localparam int RMIN_I = 1 - WIDTH;
  localparam logic signed [SW-1:0] RMAX = RMAX_I[SW-1:0];
  localparam logic signed [SW-1:0] RMIN = RMIN_I[SW-1:0];
  localparam logic signed [SW-1:0] ONE  = 1;

  typedef struct packed {
    logic [W_REG-1:0] regime;
    logic [EW-1:0]    exponent;
    logic [W_MAN-1:0] mantissa;
    logic             is_zero;
    logic             sat_hi;
    logic             sat_lo;
  } res_t;

  function automatic logic [NZ_W-1:0] lead_zeros(input logic [W_MAN-1:0] v);
    lead_zeros = NZ_W'(W_MAN);
    for (int i = 0; i < W_MAN; i++) begin
      if (v[i]) lead_zeros = NZ_W'(W_MAN - 1 - i);
    end
  endfunction

  // Floor split of scale into regime/exponent, clamped to the legal regime range.
  function automatic res_t normalise(input logic zero,
                                     input logic signed [SW-1:0] scale,
                                     input logic [W_MAN-1:0] frac);
    logic signed [SW-1:0] r;
    res_t res;
    r   = scale >>> ES;
    res = '0;
    if (zero) begin
      res.regime  = {1'b1, {(W_REG-1){1'b0}}};
      res.is_zero = 1'b1;
    end else if (r > RMAX) begin
      res.regime = RMAX[W_REG-1:0];
      res.sat_hi = 1'b1;
    end else if (r < RMIN) begin
      res.regime = RMIN[W_REG-1:0];
      res.sat_lo = 1'b1;
    end else begin
      res.regime   = r[W_REG-1:0];
      res.exponent = (ES == 0) ? '0 : scale[EW-1:0];
      res.mantissa = frac;
    end
    return res;
  endfunction

  logic                 vld_p1, vld_p2;
  logic                 s1_rdy, s2_rdy;
  logic [W_MAN-1:0]     mant1_p1;
  logic signed [SW-1:0] scale_p1;
  logic                 zero_p1;
  logic [TAG_W-1:0]     tag_p1, tag_p2;
  res_t                 res_p2;

  logic [NZ_W-1:0]      nz_p0;
  logic [W_MAN-1:0]     mant1_p0;
  logic signed [SW-1:0] k_ext_p0, e_ext_p0, nz_ext_p0, scale_p0;
  res_t                 res_p1;

  assign s2_rdy   = !vld_p2 || out_ready;
  assign s1_rdy   = !vld_p1 || s2_rdy;
  assign in_ready = s1_rdy;

  // Stage 0 -> 1: leading-zero count, hidden-bit removal and combined scale
  always_comb begin
    nz_p0     = lead_zeros(mantissa_sum);
    mant1_p0  = (mantissa_sum << nz_p0) << 1;
    k_ext_p0  = SW'(interim_regime);
    e_ext_p0  = SW'(interim_exponent);
    nz_ext_p0 = signed'(SW'(nz_p0));
    scale_p0  = (k_ext_p0 <<< ES) + e_ext_p0 + ONE - nz_ext_p0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      mant1_p1 <= '0;
      scale_p1 <= '0;
      zero_p1  <= 1'b0;
      tag_p1   <= '0;
    end else if (s1_rdy) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        mant1_p1 <= mant1_p0;
        scale_p1 <= scale_p0;
        zero_p1  <= (mantissa_sum == '0);
        tag_p1   <= in_tag;
      end
    end
  end

  // Stage 1 -> 2: regime/exponent split, clamp and flags
  assign res_p1 = normalise(zero_p1, scale_p1, mant1_p1);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      res_p2 <= '0;
      tag_p2 <= '0;
    end else if (s2_rdy) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        res_p2 <= res_p1;
        tag_p2 <= tag_p1;
      end
    end
  end

  assign out_valid = vld_p2;
  assign mantissa  = res_p2.mantissa;
  assign regime    = signed'(res_p2.regime);
  assign exponent  = res_p2.exponent;
  assign is_zero   = res_p2.is_zero;
  assign sat_hi    = res_p2.sat_hi;
  assign sat_lo    = res_p2.sat_lo;
  assign out_tag   = tag_p2;

endmodule

// File: tb/tb_normalise_pipe.sv
// Directed bench for normalise_pipe: ES=1 instance for function, flow control
// and reset; ES=0/2/3 instances checked against a floor/clamp reference model.
module tb_normalise_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] ms, mant;
  logic [3:0] k, e, in_tag, out_tag, regime;
  logic [0:0] exponent;
  logic       is_zero, sat_hi, sat_lo;

  logic       s_v, s_rdy;
  logic [7:0] s_ms;
  logic [3:0] s_k, s_e, s_tag;
  logic       r0_in, r2_in, r3_in, v0, v2, v3;
  logic [7:0] m0, m2, m3;
  logic [3:0] g0, g2, g3, t0, t2, t3;
  logic [0:0] x0;
  logic [1:0] x2;
  logic [2:0] x3;
  logic [2:0] f0, f2, f3;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  normalise_pipe #(.WIDTH(8), .ES(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mantissa_sum(ms), .interim_regime(k), .interim_exponent(e), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .mantissa(mant), .regime(regime),
    .exponent(exponent), .is_zero(is_zero), .sat_hi(sat_hi), .sat_lo(sat_lo),
    .out_tag(out_tag));

  normalise_pipe #(.WIDTH(8), .ES(0)) u_es0 (
    .clk(clk), .rst(rst), .in_valid(s_v), .in_ready(r0_in),
    .mantissa_sum(s_ms), .interim_regime(s_k), .interim_exponent(s_e), .in_tag(s_tag),
    .out_valid(v0), .out_ready(s_rdy), .mantissa(m0), .regime(g0),
    .exponent(x0), .is_zero(f0[2]), .sat_hi(f0[1]), .sat_lo(f0[0]), .out_tag(t0));

  normalise_pipe #(.WIDTH(8), .ES(2)) u_es2 (
    .clk(clk), .rst(rst), .in_valid(s_v), .in_ready(r2_in),
    .mantissa_sum(s_ms), .interim_regime(s_k), .interim_exponent(s_e), .in_tag(s_tag),
    .out_valid(v2), .out_ready(s_rdy), .mantissa(m2), .regime(g2),
    .exponent(x2), .is_zero(f2[2]), .sat_hi(f2[1]), .sat_lo(f2[0]), .out_tag(t2));

  normalise_pipe #(.WIDTH(8), .ES(3)) u_es3 (
    .clk(clk), .rst(rst), .in_valid(s_v), .in_ready(r3_in),
    .mantissa_sum(s_ms), .interim_regime(s_k), .interim_exponent(s_e), .in_tag(s_tag),
    .out_valid(v3), .out_ready(s_rdy), .mantissa(m3), .regime(g3),
    .exponent(x3), .is_zero(f3[2]), .sat_hi(f3[1]), .sat_lo(f3[0]), .out_tag(t3));

  typedef struct {
    logic [3:0] rg;
    int         x;
    logic [7:0] man;
    logic [2:0] flags;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: floor division for the regime, remainder for the exponent.
  function automatic exp_t model(input logic [7:0] m, input int kk, input int ee, input int es);
    exp_t res;
    int nz, scale, pw, r, mw;
    logic found;
    nz = 8;
    found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && !found) begin
        nz = 7 - i;
        found = 1'b1;
      end
    end
    pw = 1 << es;
    scale = kk * pw + ee + 1 - nz;
    r = (scale >= 0) ? scale / pw : -((-scale + pw - 1) / pw);
    mw = int'(m) << (nz + 1);
    res.rg = 4'h0; res.x = 0; res.man = 8'h00; res.flags = 3'b000;
    if (m == 8'h00) begin
      res.rg = 4'b1000; res.flags = 3'b100;
    end else if (r > 6) begin
      res.rg = 4'd6; res.flags = 3'b010;
    end else if (r < -7) begin
      res.rg = 4'b1001; res.flags = 3'b001;
    end else begin
      res.rg = r[3:0]; res.x = scale - r * pw; res.man = mw[7:0];
    end
    return res;
  endfunction

  // Drive one beat on the ES=1 instance and check the 2-cycle latency.
  task automatic send1(input logic [7:0] m, input int kk, input int ee, input logic [3:0] t);
    in_valid = 1'b1; ms = m; k = kk[3:0]; e = ee[3:0]; in_tag = t; out_ready = 1'b1;
    #1;
    chk("send_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("lat_t1_valid", out_valid, 0);
    @(negedge clk);
    #1;
    chk("lat_t2_valid", out_valid, 1);
    chk("lat_t2_tag", out_tag, t);
  endtask

  int sent, recv, acc;
  logic stalled;
  logic [3:0] h_tag;
  logic [7:0] h_man;
  logic [15:0] pat;
  exp_t ex;
  int kk, ee;

  initial begin
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    ms = 8'hFF; k = 4'h3; e = 4'h1; in_tag = 4'hA;
    s_v = 1'b0; s_rdy = 1'b1; s_ms = 8'h00; s_k = 4'h0; s_e = 4'h0; s_tag = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_regime", regime, 0);
    chk("rst_mant", mant, 0);
    chk("rst_exp", exponent, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_flags", {is_zero, sat_hi, sat_lo}, 3'b000);

    send1(8'b0011_0000, 0, 0, 4'h1);
    chk("basic_man", mant, 8'h80);
    chk("basic_regime", regime, 4'hF);
    chk("basic_exp", exponent, 1);
    chk("basic_flags", {is_zero, sat_hi, sat_lo}, 3'b000);

    @(negedge clk);
    send1(8'b1000_0000, 2, 1, 4'h2);
    chk("carry_man", mant, 8'h00);
    chk("carry_regime", regime, 4'd3);
    chk("carry_exp", exponent, 0);
    chk("carry_flags", {is_zero, sat_hi, sat_lo}, 3'b000);

    @(negedge clk);
    send1(8'h00, 5, 0, 4'h3);
    chk("zero_regime", regime, 4'b1000);
    chk("zero_man", mant, 8'h00);
    chk("zero_exp", exponent, 0);
    chk("zero_flags", {is_zero, sat_hi, sat_lo}, 3'b100);

    @(negedge clk);
    send1(8'b1000_0000, 6, 1, 4'h4);
    chk("sathi_regime", regime, 4'd6);
    chk("sathi_exp", exponent, 0);
    chk("sathi_man", mant, 8'h00);
    chk("sathi_flags", {is_zero, sat_hi, sat_lo}, 3'b010);

    @(negedge clk);
    send1(8'b0000_0001, -7, 0, 4'h5);
    chk("satlo_regime", regime, 4'b1001);
    chk("satlo_exp", exponent, 0);
    chk("satlo_man", mant, 8'h00);
    chk("satlo_flags", {is_zero, sat_hi, sat_lo}, 3'b001);

    // Full throughput with out_ready high: in_ready never drops, tags in order.
    @(negedge clk);
    out_ready = 1'b1; k = 4'h0; e = 4'h0; ms = 8'h40;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 8);
      in_tag = i[3:0];
      #1;
      chk("thru_in_ready", in_ready, 1);
      if (i >= 2) begin
        chk("thru_valid", out_valid, 1);
        chk("thru_tag", out_tag, i - 2);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    chk("thru_drained", out_valid, 0);

    // Backpressure on a fixed pseudo-random out_ready pattern.
    pat = 16'b0110_1001_1100_1011;
    sent = 0; recv = 0; stalled = 1'b0; h_tag = 4'h0; h_man = 8'h00;
    for (int c = 0; c < 200 && recv < 10; c++) begin
      out_ready = pat[c % 16];
      in_valid = (sent < 10);
      in_tag = sent[3:0];
      ms = 8'h40 | {4'h0, sent[3:0]};
      #1;
      if (stalled) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_tag", out_tag, h_tag);
        chk("hold_man", mant, h_man);
      end
      if (out_valid && out_ready) begin
        chk("bp_order", out_tag, recv);
        chk("bp_man", mant, (recv << 2) & 8'hFF);
        recv++;
      end
      stalled = out_valid && !out_ready;
      h_tag = out_tag;
      h_man = mant;
      if (in_valid && in_ready) sent++;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_recv_count", recv, 10);
    #1;
    chk("bp_no_extra", out_valid, 0);

    // Stalled output: exactly two beats fit before in_ready falls.
    @(negedge clk);
    out_ready = 1'b0; acc = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_tag = 4'(i + 8);
      #1;
      if (in_ready) acc++;
      @(negedge clk);
    end
    #1;
    chk("stall_accepts", acc, 2);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);

    // Reset with both stages full.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_tag", out_tag, 0);
    send1(8'b0011_0000, 0, 0, 4'hC);
    chk("mrst_man", mant, 8'h80);
    chk("mrst_regime", regime, 4'hF);
    @(negedge clk);
    #1;
    chk("mrst_no_stale", out_valid, 0);

    // ES sweep on the ES=0/2/3 instances.
    for (int v = 0; v < 24; v++) begin
      case (v)
        0: begin s_ms = 8'h80; kk = 7;  ee = 7;  end
        1: begin s_ms = 8'h01; kk = -8; ee = -8; end
        2: begin s_ms = 8'h00; kk = 3;  ee = -8; end
        3: begin s_ms = 8'h5A; kk = 0;  ee = 7;  end
        4: begin s_ms = 8'h13; kk = -1; ee = -8; end
        default: begin
          s_ms = 8'($urandom_range(0, 255));
          kk = int'($urandom_range(0, 15)) - 8;
          ee = int'($urandom_range(0, 15)) - 8;
        end
      endcase
      s_k = kk[3:0]; s_e = ee[3:0]; s_tag = v[3:0]; s_v = 1'b1;
      @(negedge clk);
      s_v = 1'b0;
      @(negedge clk);
      #1;
      ex = model(s_ms, kk, ee, 0);
      chk("es0_valid", v0, 1);
      chk("es0_regime", g0, ex.rg);
      chk("es0_exp", x0, ex.x);
      chk("es0_man", m0, ex.man);
      chk("es0_flags", f0, ex.flags);
      ex = model(s_ms, kk, ee, 2);
      chk("es2_regime", g2, ex.rg);
      chk("es2_exp", x2, ex.x);
      chk("es2_man", m2, ex.man);
      chk("es2_flags", f2, ex.flags);
      ex = model(s_ms, kk, ee, 3);
      chk("es3_regime", g3, ex.rg);
      chk("es3_exp", x3, ex.x);
      chk("es3_man", m3, ex.man);
      chk("es3_flags", f3, ex.flags);
      chk("es3_tag", t3, v[3:0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
